mem_arbiter: RTL and testbench

Two-port arbiter/sequencer sharing the single-port, synchronous-read data memory between the CPU instruction-fetch port (IF) and the load/store port (D). It sits inside `CPU` between the datapath and the memory instance. It serialises accesses with a four-state FSM and returns one-cycle ack pulses with registered read data. Data accesses have priority; an optional starvation guard bounds IF wait.

---
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one synchronous-read memory between instruction fetch (IF) and load/store (D).
// Optional starvation guard for IF is enabled by defining ARB_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int AW         = 12,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_ACK
  } state_t;

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("mem_arbiter: STARVE_MAX must lie in 1..15");
  end

  state_t        r_state;
  logic          r_own;
  logic          r_is_wr;
  logic          r_mem_en;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_if_ack;
  logic          r_d_ack;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_d_rdata;

  logic          w_any_req;
  logic          w_grant_d;

  assign w_any_req = if_req | d_req;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] r_starve_cnt;
  logic       w_force_if;

  // IF takes the slot once D has won STARVE_MAX arbitrations in a row against it.
  assign w_force_if = (r_starve_cnt == 4'(STARVE_MAX));
  assign w_grant_d  = d_req & ~(if_req & w_force_if);
`else
  assign w_grant_d  = d_req;
`endif

  // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_own        <= 1'b0;
      r_is_wr      <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_ack     <= 1'b0;
      r_d_ack      <= 1'b0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
`ifdef ARB_STARVE_GUARD_EN
      r_starve_cnt <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_own      <= w_grant_d;
            r_is_wr    <= w_grant_d & d_we;
            r_mem_we   <= w_grant_d & d_we;
            r_mem_addr <= w_grant_d ? d_addr : if_addr;
            if (w_grant_d) begin
              r_mem_wdata <= d_wdata;
            end
            r_mem_en   <= 1'b1;
            r_state    <= S_ACCESS;
`ifdef ARB_STARVE_GUARD_EN
            if (w_grant_d && if_req) begin
              r_starve_cnt <= r_starve_cnt + 4'd1;
            end else begin
              r_starve_cnt <= '0;
            end
`endif
          end
        end
        S_ACCESS: begin
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          // Read data is valid now; writes leave the D read-data register untouched.
          if (r_own) begin
            r_d_ack <= 1'b1;
            if (!r_is_wr) begin
              r_d_rdata <= mem_rdata;
            end
          end else begin
            r_if_ack   <= 1'b1;
            r_if_rdata <= mem_rdata;
          end
          r_state <= S_ACK;
        end
        S_ACK: begin
          r_if_ack <= 1'b0;
          r_d_ack  <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign if_ack    = r_if_ack;
  assign if_rdata  = r_if_rdata;
  assign d_ack     = r_d_ack;
  assign d_rdata   = r_d_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic against a slot-level model.
module tb_mem_arbiter;

  localparam int AW         = 12;
  localparam int DW         = 32;
  localparam int STARVE_MAX = 4;
  localparam int DEPTH      = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] mem_rdata;
  logic          if_ack, d_ack, mem_en, mem_we;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  always #5 clock = ~clock;

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
    .clock    (clock),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ack   (if_ack),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [DW-1:0] init_word(logic [AW-1:0] a);
    if (a == AW'(4)) return 32'h2010_0009;
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  // Physical memory: synchronous read, unwritten words return their initial pattern.
  logic [DW-1:0] ram      [DEPTH];
  bit            ram_wr   [DEPTH];
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]    <= mem_wdata;
        ram_wr[mem_addr] <= 1'b1;
      end
      mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : init_word(mem_addr);
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: one slot of four cycles per granted access, ack two cycles after the grant edge.
  logic [DW-1:0] gold [DEPTH];
  int            cyc = 0;
  int            free_at = 0;
  bit            g_valid = 0;
  int            g_cyc = 0;
  bit            g_own = 0;
  bit            g_we = 0;
  logic [AW-1:0] g_addr = '0;
  logic [DW-1:0] g_wdata = '0;
  logic [DW-1:0] g_rdata = '0;
  logic [DW-1:0] m_if_rdata = '0;
  logic [DW-1:0] m_d_rdata = '0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  int            m_starve = 0;

  int n_if_ack = 0, n_d_ack = 0, n_we_cyc = 0;
  int last_if_ack_cyc = 0, last_d_ack_cyc = 0;
  bit hold_if = 0, hold_d = 0;
  bit ack_log[$];

  task automatic model_reset();
    free_at    = 0;
    g_valid    = 0;
    m_if_rdata = '0;
    m_d_rdata  = '0;
    m_addr     = '0;
    m_wdata    = '0;
    m_starve   = 0;
  endtask

  task automatic model_edge();
    bit pick_d;
    if (!reset) return;
    if (g_valid && cyc == g_cyc + 2) begin
      if (!g_own) m_if_rdata = g_rdata;
      else if (!g_we) m_d_rdata = g_rdata;
      if (g_we) gold[g_addr] = g_wdata;
    end
    if (cyc >= free_at && (if_req || d_req)) begin
      pick_d = d_req;
`ifdef ARB_STARVE_GUARD_EN
      if (d_req && if_req && m_starve == STARVE_MAX) pick_d = 0;
      m_starve = (pick_d && if_req) ? m_starve + 1 : 0;
`endif
      g_valid = 1;
      g_cyc   = cyc;
      g_own   = pick_d;
      g_we    = pick_d && d_we;
      g_addr  = pick_d ? d_addr : if_addr;
      g_wdata = d_wdata;
      g_rdata = gold[g_addr];
      m_addr  = g_addr;
      if (pick_d) m_wdata = d_wdata;
      free_at = cyc + 4;
    end
  endtask

  task automatic compare_and_react();
    bit exp_en, exp_we, exp_if_ack, exp_d_ack;
    exp_en     = g_valid && cyc == g_cyc;
    exp_we     = exp_en && g_we;
    exp_if_ack = g_valid && cyc == g_cyc + 2 && !g_own;
    exp_d_ack  = g_valid && cyc == g_cyc + 2 && g_own;
    check("ctl{if_ack,d_ack,en,we}", 64'({if_ack, d_ack, mem_en, mem_we}),
          64'({exp_if_ack, exp_d_ack, exp_en, exp_we}));
    check("mem_addr", 64'(mem_addr), 64'(m_addr));
    check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    check("if_rdata", 64'(if_rdata), 64'(m_if_rdata));
    check("d_rdata", 64'(d_rdata), 64'(m_d_rdata));
    if (mem_we) n_we_cyc++;
    if (if_ack) begin
      n_if_ack++;
      last_if_ack_cyc = cyc;
      ack_log.push_back(1'b0);
      if (hold_if) if_addr = AW'($urandom_range(DEPTH - 1));
      else if_req = 1'b0;
    end
    if (d_ack) begin
      n_d_ack++;
      last_d_ack_cyc = cyc;
      ack_log.push_back(1'b1);
      if (hold_d) begin
        d_we    = 1'($urandom_range(1));
        d_addr  = AW'($urandom_range(63));
        d_wdata = DW'($urandom);
      end else begin
        d_req = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    cyc++;
    model_edge();
    @(negedge clock);
    compare_and_react();
  endtask

  task automatic wait_acks(input string tag, input int want_if, input int want_d, input int budget);
    int i0, d0, k;
    i0 = n_if_ack;
    d0 = n_d_ack;
    k  = 0;
    while ((n_if_ack - i0 < want_if || n_d_ack - d0 < want_d) && k < budget) begin
      step();
      k++;
    end
    check({tag, "_if_acks"}, 64'(n_if_ack - i0), 64'(want_if));
    check({tag, "_d_acks"}, 64'(n_d_ack - d0), 64'(want_d));
  endtask

  task automatic hold_reset(input int n);
    reset  = 1'b0;
    if_req = 1'b0;
    d_req  = 1'b0;
    model_reset();
    repeat (n) step();
    reset = 1'b1;
  endtask

  initial begin
    int e0, we0, d_before;
    for (int i = 0; i < DEPTH; i++) gold[i] = init_word(AW'(i));

    // Reset held four cycles, then idle: all outputs zero, no memory activity.
    hold_reset(4);
    check("reset_outputs", 64'({if_ack, d_ack, mem_en, mem_we, mem_addr, mem_wdata, if_rdata}), 64'(0));
    check("reset_d_rdata", 64'(d_rdata), 64'(0));
    repeat (4) step();

    // IF read of the preloaded instruction word.
    if_req  = 1'b1;
    if_addr = AW'(12'h004);
    e0      = cyc + 1;
    wait_acks("if_read", 1, 0, 10);
    check("if_read_latency", 64'(last_if_ack_cyc - e0), 64'(2));
    check("if_read_data", 64'(if_rdata), 64'(32'h2010_0009));
    repeat (2) step();

    // D write then D read of the same word.
    we0     = n_we_cyc;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = AW'(12'h010);
    d_wdata = 32'hDEAD_BEEF;
    wait_acks("d_write", 0, 1, 10);
    check("d_rdata_after_write", 64'(d_rdata), 64'(0));
    d_req = 1'b1;
    d_we  = 1'b0;
    wait_acks("d_read", 0, 1, 10);
    check("d_read_data", 64'(d_rdata), 64'(32'hDEAD_BEEF));
    check("mem_we_cycles", 64'(n_we_cyc - we0), 64'(1));
    repeat (2) step();

    // Simultaneous requests: D first, IF in the following slot.
    if_req  = 1'b1;
    if_addr = AW'(12'h010);
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = AW'(12'h004);
    e0      = cyc + 1;
    wait_acks("simul", 1, 1, 12);
    check("simul_d_latency", 64'(last_d_ack_cyc - e0), 64'(2));
    check("simul_if_latency", 64'(last_if_ack_cyc - e0), 64'(6));
    check("simul_if_data", 64'(if_rdata), 64'(32'hDEAD_BEEF));
    repeat (4) step();

    // Both requests held continuously.
    ack_log.delete();
    hold_if = 1;
    hold_d  = 1;
    if_req  = 1'b1;
    if_addr = AW'($urandom_range(DEPTH - 1));
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = AW'($urandom_range(63));
    repeat (100) step();
`ifdef ARB_STARVE_GUARD_EN
    check("starve_log_len", 64'(ack_log.size() >= 15), 64'(1));
    for (int i = 0; i < 15 && i < ack_log.size(); i++)
      check("starve_pattern", 64'(ack_log[i]), 64'((i % (STARVE_MAX + 1)) != STARVE_MAX));
`else
    check("starve_d_count", 64'(ack_log.size() >= 5 * STARVE_MAX), 64'(1));
    for (int i = 0; i < ack_log.size(); i++)
      if (!ack_log[i]) check("starve_no_if_ack", 64'(ack_log[i]), 64'(1));
    check("starve_if_acks", 64'(n_if_ack), 64'(2));
`endif
    hold_if = 0;
    hold_d  = 0;
    repeat (12) step();
    if_req = 1'b0;
    d_req  = 1'b0;
    repeat (4) step();

    // Random traffic on a small D address window to exercise read-after-write.
    for (int n = 0; n < 400; n++) begin
      step();
      if (!if_req && $urandom_range(3) == 0) begin
        if_req  = 1'b1;
        if_addr = AW'($urandom_range(63));
      end
      if (!d_req && $urandom_range(2) == 0) begin
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(1));
        d_addr  = AW'($urandom_range(63));
        d_wdata = DW'($urandom);
      end
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    repeat (8) step();

    // Reset during the access cycle of a D write aborts it without an ack.
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = AW'(12'h020);
    d_wdata = 32'h1234_5678;
    for (int k = 0; k < 8 && !mem_en; k++) step();
    check("abort_in_access", 64'({mem_en, mem_we}), 64'(2'b11));
    d_before = n_d_ack;
    reset    = 1'b0;
    #1;
    check("abort_en_we_drop", 64'({mem_en, mem_we}), 64'(0));
    hold_reset(3);
    repeat (4) step();
    check("abort_no_ack", 64'(n_d_ack), 64'(d_before));
    d_req = 1'b1;
    d_we  = 1'b0;
    e0    = cyc + 1;
    wait_acks("post_abort_read", 0, 1, 10);
    check("post_abort_latency", 64'(last_d_ack_cyc - e0), 64'(2));
    check("post_abort_data", 64'(d_rdata), 64'(init_word(AW'(12'h020))));
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
